// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, 15-entry register file (R15 reads as PC+8),
// register read with write-through, immediate extension, ID/EX register.
// Latency: InstrF at edge n -> InstrD after edge n -> E outputs after edge n+1.
// Backpressure: StallD holds IF/ID and sends a bubble into ID/EX. FlushD
// squashes IF/ID. FlushE squashes ID/EX. RST overrides every other control.
// Ports: CLK/RST; fetch inputs InstrF/PCF/R15F; hazard controls StallD/FlushD/FlushE;
//   write-back RegWriteW/WA3W/WD3W; IF/ID view ValidD/InstrD; ID/EX outputs
//   ValidE, RD1E/RD2E, ExtImmE, RA1E/RA2E, WA3E, CondE, OpE, FunctE, PCE.
module decode_stage #(
  parameter int DW    = 32,
  parameter int NREGS = 15
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [31:0]   InstrF,
  input  logic [31:0]   PCF,
  input  logic [31:0]   R15F,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          FlushE,
  input  logic          RegWriteW,
  input  logic [3:0]    WA3W,
  input  logic [DW-1:0] WD3W,
  output logic          ValidD,
  output logic [31:0]   InstrD,
  output logic          ValidE,
  output logic [DW-1:0] RD1E,
  output logic [DW-1:0] RD2E,
  output logic [31:0]   ExtImmE,
  output logic [3:0]    RA1E,
  output logic [3:0]    RA2E,
  output logic [3:0]    WA3E,
  output logic [3:0]    CondE,
  output logic [1:0]    OpE,
  output logic [5:0]    FunctE,
  output logic [31:0]   PCE
);

  // IF/ID fields not exported as ports
  logic [31:0]   id_pc;
  logic [DW-1:0] id_r15;

  logic [DW-1:0] regs [NREGS];

  // Decode results (combinational on InstrD)
  logic [1:0]    op;
  logic [3:0]    ra1;
  logic [3:0]    ra2;
  logic [31:0]   ext_imm;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rd2;
  logic          wr_en;

  // R15 is not stored; a write-back to it belongs to the fetch path.
  assign wr_en = RegWriteW && (WA3W != 4'd15);

  always_comb begin
    op  = InstrD[27:26];
    ra1 = (op == 2'b10) ? 4'd15 : InstrD[19:16];
    ra2 = (op == 2'b01) ? InstrD[15:12] : InstrD[3:0];

    ext_imm = '0;
    case (op)
      2'b00:   ext_imm = {24'b0, InstrD[7:0]};
      2'b01:   ext_imm = {20'b0, InstrD[11:0]};
      2'b10:   ext_imm = {{6{InstrD[23]}}, InstrD[23:0], 2'b00};
      default: ext_imm = '0;
    endcase

    // Write-through so an instruction in D sees the value WB writes this cycle.
    rd1 = '0;
    if (ra1 == 4'd15)                   rd1 = id_r15;
    else if (wr_en && (WA3W == ra1))    rd1 = WD3W;
    else                                rd1 = regs[ra1];

    rd2 = '0;
    if (ra2 == 4'd15)                   rd2 = id_r15;
    else if (wr_en && (WA3W == ra2))    rd2 = WD3W;
    else                                rd2 = regs[ra2];
  end

  // IF/ID register
  always_ff @(posedge CLK) begin
    if (RST || FlushD) begin
      ValidD <= 1'b0;
      InstrD <= '0;
      id_pc  <= '0;
      id_r15 <= '0;
    end else if (!StallD) begin
      ValidD <= 1'b1;
      InstrD <= InstrF;
      id_pc  <= PCF;
      id_r15 <= R15F;
    end
  end

  // ID/EX register; a stall in D leaves E empty rather than duplicating the op.
  always_ff @(posedge CLK) begin
    if (RST || FlushE || StallD) begin
      ValidE  <= 1'b0;
      RD1E    <= '0;
      RD2E    <= '0;
      ExtImmE <= '0;
      RA1E    <= '0;
      RA2E    <= '0;
      WA3E    <= '0;
      CondE   <= '0;
      OpE     <= '0;
      FunctE  <= '0;
      PCE     <= '0;
    end else begin
      ValidE  <= ValidD;
      RD1E    <= rd1;
      RD2E    <= rd2;
      ExtImmE <= ext_imm;
      RA1E    <= ra1;
      RA2E    <= ra2;
      WA3E    <= InstrD[15:12];
      CondE   <= InstrD[31:28];
      OpE     <= op;
      FunctE  <= InstrD[25:20];
      PCE     <= id_pc;
    end
  end

  // Register file; a write coinciding with RST is discarded.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[WA3W] <= WD3W;
    end
  end

endmodule
